// File: rtl/print_arbiter.sv
// print_arbiter: round-robin sharing of one printer port among
// N_REQ byte requesters, with strobe/ready handshake and stall timeout.
module print_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  input  logic                     print_ready,
  output logic [7:0]               print_data,
  output logic                     pulse_request,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] cur_id,
  input  logic                     err_clr,
  output logic                     err_pulse,
  output logic                     err_sticky
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_ack;
  logic             r_pulse;
  logic [7:0]       r_data;
  logic             r_busy;
  logic [IW-1:0]    r_cur_id;
  logic [TW-1:0]    r_timer;
  logic             r_err_pulse;
  logic             r_err_sticky;

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_oh;
  logic [IW-1:0]    w_idx  [N_REQ+1];
  logic [7:0]       w_byte [N_REQ+1];
  logic             w_grant;
  logic             w_tmax;

  // Prefer requesters above cur_id; otherwise wrap to the lowest set bit.
  assign w_cand    = (|w_hi) ? w_hi : req;
  assign w_idx[0]  = '0;
  assign w_byte[0] = 8'h00;

  genvar i;
  generate
    for (i = 0; i < N_REQ; i++) begin : g_sel
      if (i == 0) begin : g_first
        assign w_hi[i] = 1'b0;
        assign w_oh[i] = w_cand[i];
      end else begin : g_rest
        assign w_hi[i] = req[i] & (r_cur_id < IW'(i));
        assign w_oh[i] = w_cand[i] & ~|w_cand[i-1:0];
      end
      assign w_idx[i+1] =
        w_idx[i] | (w_oh[i] ? IW'(i) : '0);
      assign w_byte[i+1] =
        w_byte[i] | (w_oh[i] ? req_data[8*i +: 8] : 8'h00);
    end
  endgenerate

  assign w_grant = (|req) & print_ready;
  assign w_tmax  = (r_timer == TMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ack        <= '0;
      r_pulse      <= 1'b0;
      r_data       <= 8'h00;
      r_busy       <= 1'b0;
      r_cur_id     <= IW'(N_REQ - 1);
      r_timer      <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (err_clr) r_err_sticky <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_data   <= w_byte[N_REQ];
            r_ack    <= w_oh;
            r_pulse  <= 1'b1;
            r_cur_id <= w_idx[N_REQ];
            r_busy   <= 1'b1;
            r_state  <= STROBE;
          end
        end
        STROBE: begin
          r_pulse <= 1'b0;
          r_ack   <= '0;
          r_timer <= '0;
          r_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!print_ready) begin
            r_timer <= '0;
            r_state <= WAIT_HIGH;
          end else if (w_tmax) begin
            r_err_pulse  <= 1'b1;
            r_err_sticky <= 1'b1;
            r_timer      <= '0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (print_ready) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_tmax) begin
            r_err_pulse  <= 1'b1;
            r_err_sticky <= 1'b1;
            r_timer      <= '0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack           = r_ack;
  assign pulse_request = r_pulse;
  assign print_data    = r_data;
  assign busy          = r_busy;
  assign cur_id        = r_cur_id;
  assign err_pulse     = r_err_pulse;
  assign err_sticky    = r_err_sticky;

endmodule

// File: doc/print_arbiter.md
# print_arbiter

Shares one printer port among `N_REQ` byte-producing requesters, such as several output-controller channels or CPU ports. It sits between the requesters and the printer interface. Each cycle it is idle, it selects one pending requester by round-robin and latches that requester's byte. It then runs the strobe/ready handshake with the printer. It watches the printer for stalls and flags a timeout if one occurs.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 1024: maximum cycles spent in either wait state before abort. Must be ≥ 2.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req`, input, N_REQ: `req[i]` high means requester i has a byte. It is held until `ack[i]`.
- `req_data`, input, 8*N_REQ: byte of requester i on bits `[8i+7:8i]`. It is stable while `req[i]` is high.
- `ack`, output, N_REQ: one-cycle pulse that tells requester i its byte was taken.
- `print_ready`, input, 1: printer can accept a byte (high = ready).
- `print_data`, output, 8: byte presented to the printer. It holds its value until the next grant.
- `pulse_request`, output, 1: one-cycle strobe to the printer.
- `busy`, output, 1: high whenever the state is not IDLE.
- `cur_id`, output, clog2(N_REQ): index of the last granted requester.
- `err_clr`, input, 1: clears `err_sticky`.
- `err_pulse`, output, 1: one-cycle pulse when a timeout abort occurs.
- `err_sticky`, output, 1: set by `err_pulse`. It stays set until `err_clr` is asserted or reset.

## Operation
FSM states: IDLE, STROBE, WAIT_LOW, WAIT_HIGH.

- IDLE
  - When `|req` and `print_ready` are both high, a grant is made.
  - Selected index g is the first set `req` bit searching upward from `cur_id+1`, with modulo wrap-around.
  - Registered on that edge: `print_data<=req_data[g]`, `ack[g]<=1`, `pulse_request<=1`, `cur_id<=g`, state<=STROBE.
  - When `req` is non-zero but `print_ready` is low, there is no grant and the FSM stays in IDLE.
- STROBE
  - Registered on exit: `pulse_request<=0`, `ack<=0`, timer<=0, state<=WAIT_LOW.
- WAIT_LOW
  - If `print_ready==0`, go to WAIT_HIGH with timer<=0.
  - Else if timer==TIMEOUT-1, abort.
  - Else timer+1.
- WAIT_HIGH
  - If `print_ready==1`, go to IDLE.
  - Else if timer==TIMEOUT-1, abort.
  - Else timer+1.
- Abort
  - Registered: `err_pulse<=1` for one cycle, `err_sticky<=1`, state<=IDLE.
  - The byte is dropped and is not retried. The requester was already acked.
- Timer
  - Width is clog2(TIMEOUT). It saturates, so it never wraps.
  - An abort therefore happens exactly TIMEOUT cycles after entering the wait state.
- `err_clr` and a new `err_pulse` in the same cycle: set wins.
- Requesters
  - A requester may raise `req` at any time. It must keep `req` high and `req_data` stable until it sees `ack`.
  - After `ack`, it may drop `req` or present the next byte with `req` still high. Round-robin then serves others first.
- `ack` is one-hot or zero. `pulse_request` and `ack` are always asserted in the same cycle.

## Timing
- Reset, sampled at a `clk` edge with `rst_n==0`, applies from any state, including mid-handshake:
  - state=IDLE
  - `ack`=0, `pulse_request`=0, `print_data`=8'h00
  - `busy`=0, `cur_id`=N_REQ-1 (so requester 0 has first priority)
  - `err_pulse`=0, `err_sticky`=0, timer=0
- A strobe in progress at reset is cut off at that edge.
- Grant latency: `req` and `print_ready` sampled high at edge k give `ack`/`pulse_request`/`print_data` valid in cycle k+1.
- Minimum byte period: 4 cycles from pulse to pulse. The sequence is STROBE, then WAIT_LOW with 1 cycle low, then WAIT_HIGH with 1 cycle high, then IDLE granting.
- Requests raised during STROBE or WAIT_* are only evaluated in IDLE.
- The output `busy` is registered as a decode of the state.

## Test plan
- Single requester
  - Stimulus: req=4'b0001, data 8'hA5, print_ready=1; printer drops ready 1 cycle after the pulse and restores it 3 cycles later.
  - Response: `print_data`=A5, one `pulse_request` and one `ack[0]` in the same cycle, `busy` high for 5 cycles, no error.
- Round-robin with all four requesting continuously
  - Stimulus: req=4'b1111 with data 8'h10/11/12/13, for 8 bytes.
  - Response: grant order 0,1,2,3,0,1,2,3; `cur_id` follows that order; each `ack` is exactly one cycle.
- Wrap-around
  - Stimulus: `cur_id`=2, req=4'b0011.
  - Response: next grant goes to 0, then 1.
- Timeout
  - Stimulus: TIMEOUT=16, print_ready held high after the pulse.
  - Response: `err_pulse` exactly 16 cycles after entering WAIT_LOW, `err_sticky`=1, back to IDLE.
  - Stimulus: `err_clr` asserted.
  - Response: `err_sticky` clears.
- Printer not ready
  - Stimulus: req=4'b0100, print_ready=0 for 10 cycles.
  - Response: no `ack` or pulse during that time; grant 1 cycle after `print_ready` rises.
- Reset mid-operation
  - Stimulus: `rst_n` low during WAIT_HIGH.
  - Response: next cycle all outputs at reset values and `cur_id`=N_REQ-1; a pending req=4'b0001 is granted once reset is released.
